// File: rtl/pc_unit.sv
// pc_unit: program counter with next-PC select, EPC/exception flag and circular return-address stack
module pc_unit #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_0000,
    parameter logic [WIDTH-1:0] EXC_VEC   = 32'h0000_0180,
    parameter int               RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_change,
    input  logic [2:0]       sel,
    input  logic [15:0]      br_off,
    input  logic [25:0]      j_tgt,
    input  logic [WIDTH-1:0] jr_addr,
    input  logic             ras_push,
    input  logic             ras_pop,
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_pc4,
    output logic [WIDTH-1:0] o_epc,
    output logic             in_exc,
    output logic             misalign,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_empty,
    output logic             ras_full
);
    localparam int PW = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0] pc_nxt, br_tgt;
    logic             jr_bad, take_exc, take_eret, push, pop;
    logic [WIDTH-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]    ptr, top_idx;
    logic [PW:0]      cnt;

    always_comb begin
        o_pc4     = o_pc + WIDTH'(4);
        br_tgt    = o_pc4 + ({{(WIDTH-16){br_off[15]}}, br_off} << 2);
        jr_bad    = sel == 3'd3 && jr_addr[1:0] != 2'b00;
        take_exc  = sel == 3'd4 || jr_bad;
        take_eret = sel == 3'd5 && in_exc;
        pc_nxt    = take_exc     ? EXC_VEC :
                    take_eret    ? o_epc :
                    sel == 3'd1  ? br_tgt :
                    sel == 3'd2  ? {o_pc4[WIDTH-1:28], j_tgt, 2'b00} :
                    sel == 3'd3  ? jr_addr : o_pc4;
        push      = pc_change && ras_push;
        pop       = pc_change && ras_pop && cnt != '0;
        top_idx   = ptr - PW'(1);
        ras_empty = cnt == '0;
        ras_full  = cnt == (PW+1)'(RAS_DEPTH);
        ras_top   = ras_empty ? '0 : ras[top_idx];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_pc     <= RESET_VEC;
            o_epc    <= '0;
            in_exc   <= 1'b0;
            misalign <= 1'b0;
            ptr      <= '0;
            cnt      <= '0;
        end else begin
            misalign <= pc_change && jr_bad;
            if (pc_change) begin
                o_pc <= pc_nxt;
                if (take_exc && !in_exc) begin
                    o_epc  <= o_pc;
                    in_exc <= 1'b1;
                end else if (take_eret) begin
                    in_exc <= 1'b0;
                end
            end
            if (push && !pop) begin
                ptr <= ptr + PW'(1);
                cnt <= ras_full ? cnt : cnt + (PW+1)'(1);
            end else if (pop && !push) begin
                ptr <= top_idx;
                cnt <= cnt - (PW+1)'(1);
            end
        end
    end

    // entries need no reset: ras_top is masked by the count
    always_ff @(posedge clk) begin
        if (rst && push)
            ras[pop ? top_idx : ptr] <= o_pc4;
    end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the multi-cycle CPU. Successor to the single-register PC.
- Holds the PC and computes the next PC internally from a select code: sequential, branch, jump, register jump, exception entry, exception return.
- Also holds an exception PC (EPC), an in-exception flag, and a small circular return-address stack (RAS) for call/return bookkeeping.
- Sits between the control FSM (pc_change/sel strobes) and the instruction-fetch address path.

Parameters:
- WIDTH, 32, PC/data width in bits.
- RESET_VEC, 32'h0000_0000, PC value after reset.
- EXC_VEC, 32'h0000_0180, exception handler entry address.
- RAS_DEPTH, 4, number of return-address stack entries (power of 2, ≥2).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- pc_change  in  1  update enable; PC/EPC/flag change only on posedge clk with pc_change=1.
- sel  in  3  next-PC select: 0 SEQ, 1 BR, 2 J, 3 JR, 4 EXC, 5 ERET; 6/7 are treated as SEQ.
- br_off  in  16  signed word offset for BR.
- j_tgt  in  26  word target for J.
- jr_addr  in  WIDTH  register value for JR.
- ras_push  in  1  push o_pc+4 onto the RAS (qualified by pc_change).
- ras_pop  in  1  pop the RAS (qualified by pc_change).
- o_pc  out  WIDTH  current PC.
- o_pc4  out  WIDTH  o_pc+4, combinational.
- o_epc  out  WIDTH  saved exception PC.
- in_exc  out  1  set while inside the exception handler.
- misalign  out  1  one-cycle pulse: JR target was not word-aligned.
- ras_top  out  WIDTH  top-of-stack value; 0 when empty.
- ras_empty  out  1  stack has no entries.
- ras_full  out  1  stack holds RAS_DEPTH entries.

Behaviour:
- Reset (rst=0, asynchronous, immediate):
  - o_pc=RESET_VEC; o_epc=0; in_exc=0; misalign=0.
  - RAS count=0, so ras_empty=1, ras_full=0, ras_top=0.
  - Reset asserted mid-operation overrides everything, including a concurrent pc_change.
- pc_change=0: all state holds; misalign=0.
- Next PC on posedge clk with pc_change=1 (all additions modulo 2^WIDTH, wrap silently):
  - SEQ: o_pc+4.
  - BR: o_pc+4 + (sign_extend(br_off)<<2).
  - J: {o_pc4[WIDTH-1:28], j_tgt, 2'b00}.
  - JR, jr_addr[1:0]==0: jr_addr.
  - JR, jr_addr[1:0]!=0: treated as EXC, and misalign=1 for exactly that cycle.
  - EXC: pc<=EXC_VEC.
    - If in_exc=0: epc<=o_pc and in_exc<=1.
    - If in_exc=1 (nested): EPC is preserved and in_exc stays 1.
  - ERET:
    - If in_exc=1: pc<=o_epc, in_exc<=0.
    - If in_exc=0: behaves as SEQ.
- Latency: new o_pc is visible one clock after the qualifying edge. o_pc4 and ras_top are combinational from registered state.
- RAS, circular buffer with pointer and count (operations act only when pc_change=1):
  - Push: entry[ptr]<=o_pc+4 (the pre-update PC), ptr<=ptr+1, count<=min(count+1, RAS_DEPTH).
  - Push when full: overwrites the oldest entry; count stays RAS_DEPTH.
  - Pop when count>0: ptr<=ptr-1, count<=count-1.
  - Pop when empty: no change.
  - Push and pop in the same cycle: replace the top entry with o_pc+4; ptr and count unchanged. If empty, this acts as a plain push.
  - ras_top = entry[ptr-1] when count>0, else 0.
- The RAS is independent of sel; the control logic decides pairing (e.g. J + push for JAL, JR + pop for return).

Test Plan:
- Reset: RESET_VEC=0x100; assert rst=0 mid-cycle → o_pc=0x100 immediately, ras_empty=1, in_exc=0. Release, 3× SEQ → o_pc=0x10C.
- BR/J: pc=0x1000.
  - BR br_off=0xFFFE → 0x0FFC.
  - Then J j_tgt=0x0000040 → 0x0000_0100.
  - pc_change=0 with sel=BR → no change.
- JR misalign: pc=0x200, JR jr_addr=0x303 → o_pc=EXC_VEC, o_epc=0x200, in_exc=1, misalign pulses for 1 cycle.
  - Then ERET → o_pc=0x200, in_exc=0.
- Nested exception: EXC at pc=0x40 → epc=0x40. At pc=0x180, EXC again → o_pc=0x180, epc still 0x40. ERET → 0x40.
- RAS overflow (RAS_DEPTH=4):
  - 5 pushes at pc=0x0,0x4,0x8,0xC,0x10 → ras_full=1, ras_top=0x14.
  - 4 pops → tops 0x10,0xC,0x8, then empty.
  - A 5th pop → no change, ras_top=0.
- Simultaneous push+pop with top=0x24 at pc=0x80 → ras_top=0x84, count unchanged.
- Wrap: pc=0xFFFF_FFFC, SEQ → 0x0000_0000.
